// File: rtl/vh_result_misr.sv
// Result-bus MISR: folds each accepted y_in into a running signature over a programmed
// number of vectors, then compares against a golden value. Optional VH_MISR_LAST_EN adds last_y.
module vh_result_misr #(
    parameter int               Y_W   = 90,
    parameter int               SIG_W = 32,
    parameter int               CNT_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 32'h04C11DB7,
    parameter logic [SIG_W-1:0] SEED  = 32'hFFFFFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic [SIG_W-1:0] exp_sig,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Y_W-1:0]   y_in,
    output logic [SIG_W-1:0] sig,
    output logic [CNT_W-1:0] vec_count,
`ifdef VH_MISR_LAST_EN
    output logic [Y_W-1:0]   last_y,
`endif
    output logic             busy,
    output logic             done,
    output logic             match
);

    localparam int N_CHUNK = (Y_W + SIG_W - 1) / SIG_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [CNT_W-1:0]   vec_count_q, vec_count_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic               match_q, match_d;
    logic               first_q, first_d;

    logic [N_CHUNK*SIG_W-1:0] y_pad;
    logic [SIG_W-1:0]         fold;
    logic [SIG_W-1:0]         misr_next;
    logic                     accept;

    always_comb begin
        y_pad = '0;
        y_pad[Y_W-1:0] = y_in;
        fold = '0;
        for (int i = 0; i < N_CHUNK; i++) begin
            fold = fold ^ y_pad[i*SIG_W +: SIG_W];
        end
        misr_next = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ fold;
    end

    assign in_ready = (state_q == ST_RUN);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        sig_d       = sig_q;
        vec_count_d = vec_count_q;
        target_d    = target_q;
        match_d     = match_q;
        first_d     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    sig_d       = SEED;
                    vec_count_d = '0;
                    target_d    = num_vec;
                    match_d     = 1'b0;
                    if (num_vec == '0) begin
                        state_d = ST_DONE;
                        first_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (state_q == ST_DONE && first_q) begin
                    // golden compare is latched once; later exp_sig changes are ignored
                    match_d = (sig_q == exp_sig);
                end
            end
            ST_RUN: begin
                if (accept) begin
                    vec_count_d = vec_count_q + CNT_W'(1);
                    sig_d       = misr_next;
                    if (vec_count_d == target_q) begin
                        state_d = ST_DONE;
                        first_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sig_q       <= SEED;
            vec_count_q <= '0;
            target_q    <= '0;
            match_q     <= 1'b0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sig_q       <= sig_d;
            vec_count_q <= vec_count_d;
            target_q    <= target_d;
            match_q     <= match_d;
            first_q     <= first_d;
        end
    end

`ifdef VH_MISR_LAST_EN
    logic [Y_W-1:0] last_y_q, last_y_d;

    assign last_y_d = accept ? y_in : last_y_q;

    always_ff @(posedge clk) begin
        if (rst) last_y_q <= '0;
        else     last_y_q <= last_y_d;
    end

    assign last_y = last_y_q;
`endif

    assign sig       = sig_q;
    assign vec_count = vec_count_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign match     = match_q;

endmodule

// File: doc/vh_result_misr.md
Name: vh_result_misr

Overview:
- Downstream capture stage for the vloghammer expression blocks.
- Consumes the 90-bit packed result bus `y` once per accepted vector and compresses a programmed number of vectors into a MISR signature.
- Compares the final signature against a golden value.
- Lets a regression check thousands of expression evaluations with one 32-bit compare instead of per-vector 90-bit checks.

Parameters:
- Y_W, 90, width of the result bus under test.
- SIG_W, 32, signature width.
- CNT_W, 16, width of the vector counter and the programmed count.
- POLY, 32'h04C11DB7, MISR feedback polynomial (SIG_W bits).
- SEED, 32'hFFFFFFFF, signature value loaded on reset and on start.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle pulse that begins a run.
- num_vec  in  CNT_W  number of vectors in the run; sampled on start.
- exp_sig  in  SIG_W  golden signature; sampled in the DONE cycle.
- in_valid  in  1  a result vector is present on y_in.
- in_ready  out  1  block accepts a vector this cycle.
- y_in  in  Y_W  result bus from the expression block.
- sig  out  SIG_W  current signature register.
- vec_count  out  CNT_W  number of vectors accepted in this run.
- busy  out  1  state is RUN.
- done  out  1  state is DONE; the signature is final.
- match  out  1  registered result of sig==exp_sig; valid while done=1.

Behaviour:
- States and transitions:
  - IDLE --start--> RUN.
  - RUN --last accept--> DONE.
  - DONE --start--> RUN.
  - Any state --rst--> IDLE.
- Reset values: state IDLE, sig=SEED, vec_count=0, in_ready=0, busy=0, done=0, match=0. A target register holds num_vec and resets to 0.
- start in IDLE or DONE:
  - Load sig=SEED, vec_count=0, target=num_vec.
  - Clear done and match.
  - Go to RUN.
- start in RUN is ignored.
- Zero-length run: if num_vec==0 at start, go to DONE on the next cycle with sig=SEED and no vectors accepted.
- in_ready=1 only in RUN. It is combinational from state.
- An accept is in_valid & in_ready. in_valid outside RUN is ignored, with no state change.
- On each accept:
  - vec_count increments.
  - sig updates, visible the following cycle (latency 1).
  - If vec_count+1==target, the next state is DONE and in_ready drops in the same edge.
- Fold: zero-pad y_in to ceil(Y_W/SIG_W)*SIG_W bits, then XOR all SIG_W-bit chunks together. For defaults: fold = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]}.
- MISR update: sig_next = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ fold. The arithmetic is unsigned modulo 2^SIG_W.
- DONE:
  - done=1.
  - sig, vec_count and match hold until start or rst.
  - match is registered on the first DONE cycle from exp_sig, so it is valid one cycle after done rises.
  - exp_sig changes after that cycle do not affect match.
- vec_count does not wrap within a run: target ≤ 2^CNT_W−1 bounds it.
- rst mid-RUN aborts the run and restores all reset values. The partial signature is discarded.
- rst has priority over start when both are asserted in the same cycle.

Optional Feature:
- Macro: VH_MISR_LAST_EN.
- When defined:
  - Adds output last_y [Y_W-1:0], which captures y_in on every accept.
  - last_y resets to 0 and holds in IDLE and DONE.
  - Gives the debug bench the final vector of a failing run.
- When undefined: the port and register are absent, and behaviour is otherwise identical.

Test Plan:
- Single zero vector: rst, start with num_vec=1, then one accept of y_in=0 → sig=32'hFB3EE249 one cycle later; done=1 and vec_count=1 on the same cycle.
- Fold check: separate runs with num_vec=1, y_in=90'h1 and y_in=(90'h1<<64) → both give sig=32'hFB3EE248.
- Backpressure and idle gaps: num_vec=3, in_valid toggling 1,0,1,0,1 → exactly 3 accepts; in_ready=0 after the third; extra in_valid after DONE leaves sig unchanged.
- Zero-length and golden compare:
  - num_vec=0 → done one cycle after start with sig=32'hFFFFFFFF.
  - exp_sig=32'hFFFFFFFF → match=1.
  - exp_sig=0 on a rerun → match=0.
- Reset mid-run: num_vec=4, rst after 2 accepts → sig=32'hFFFFFFFF, vec_count=0, busy=0; a following start runs a full 4-vector run matching a fresh-run signature.
- Restart from DONE: start while done=1 → done and match clear the next cycle, sig=SEED; start pulsed during RUN is ignored, and vec_count continues.
